// File: rtl/seq_divider_pkg.sv
// rtl/seq_divider_pkg.sv - shared divider states and default width
package div_pkg;

  localparam int DIV_WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } div_state_e;

endpackage

// File: rtl/seq_divider_if.sv
// rtl/seq_divider_if.sv - start/operand request and result bundle for seq_divider
interface seq_divider_if
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
);

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  // Requester side: issues operands, watches results.
  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  // Divider side.
  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/seq_divider_iter_counter.sv
// rtl/seq_divider_iter_counter.sv - iteration counter with clear and enable
module div_iter_counter #(
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          enable,
  output logic [CW-1:0] count
);

  // Clear wins over enable so a new operation always starts from zero.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - restoring divider, one quotient bit per clock; DIV_SIGNED_EN enables two's complement
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input logic          clk,
  input logic          reset,
  seq_divider_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  div_state_e       state_q;
  div_state_e       state_d;

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH-1:0] r_reg;

  logic [WIDTH:0]   rs;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] q_step;
  logic [WIDTH-1:0] r_step;

  logic [CW-1:0]    iter_count;
  logic             cnt_clear;
  logic             cnt_enable;
  logic             last_iter;
  logic             start_ok;
  logic             divisor_zero;

  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;
  logic [WIDTH-1:0] quotient_fix;
  logic [WIDTH-1:0] remainder_fix;

  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             dbz_q;

  assign start_ok     = (state_q == IDLE) && bus.start;
  assign divisor_zero = (bus.divisor == '0);
  assign last_iter    = (iter_count == CW'(WIDTH - 1));

  // One restoring step: try subtracting D from the shifted partial remainder.
  assign rs     = {r_reg, q_reg[WIDTH-1]};
  assign diff   = rs - {1'b0, d_reg};
  assign q_step = {q_reg[WIDTH-2:0], ~diff[WIDTH]};
  assign r_step = diff[WIDTH] ? rs[WIDTH-1:0] : diff[WIDTH-1:0];

`ifdef DIV_SIGNED_EN
  logic q_neg_q;
  logic r_neg_q;

  // The core always divides magnitudes; most-negative maps onto itself,
  // which reads correctly as an unsigned magnitude.
  assign dividend_mag = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
  assign divisor_mag  = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;

  // Remember the result signs at start for the fix-up on the final step.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else if (start_ok) begin
      q_neg_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
      r_neg_q <= bus.dividend[WIDTH-1];
    end
  end

  assign quotient_fix  = q_neg_q ? -q_step : q_step;
  assign remainder_fix = r_neg_q ? -r_step : r_step;
`else
  assign dividend_mag  = bus.dividend;
  assign divisor_mag   = bus.divisor;
  assign quotient_fix  = q_step;
  assign remainder_fix = r_step;
`endif

  div_iter_counter #(
    .CW(CW)
  ) u_iter_counter (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clear),
    .enable (cnt_enable),
    .count  (iter_count)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and counter control.
  always_comb begin
    state_d    = state_q;
    cnt_clear  = 1'b0;
    cnt_enable = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          cnt_clear = 1'b1;
          state_d   = divisor_zero ? DONE : RUN;
        end
      end
      RUN: begin
        cnt_enable = 1'b1;
        if (last_iter) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Working registers and result registers; results are loaded on the edge
  // into DONE so they are valid for the whole done cycle and then hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_reg       <= '0;
      d_reg       <= '0;
      r_reg       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            q_reg <= dividend_mag;
            d_reg <= divisor_mag;
            r_reg <= '0;
            if (divisor_zero) begin
              quotient_q  <= '1;
              remainder_q <= bus.dividend;
              dbz_q       <= 1'b1;
            end
          end
        end
        RUN: begin
          q_reg <= q_step;
          r_reg <= r_step;
          if (last_iter) begin
            quotient_q  <= quotient_fix;
            remainder_q <= remainder_fix;
            dbz_q       <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = (state_q == DONE);
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - self-checking bench for seq_divider with random reference model; honours DIV_SIGNED_EN
module tb_seq_divider;

  localparam int W = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  seq_divider_if #(.WIDTH(W)) bus ();

  seq_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference: plain arithmetic on the operands.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r,
                       output logic z, output int lat);
    if (b == 0) begin
      q = '1; r = a; z = 1'b1; lat = 1;
    end else begin
`ifdef DIV_SIGNED_EN
      int sa;
      int sb;
      sa = int'($signed(a));
      sb = int'($signed(b));
      q = W'(sa / sb);
      r = W'(sa % sb);
`else
      q = a / b;
      r = a % b;
`endif
      z = 1'b0; lat = W + 1;
    end
  endtask

  // Issue one operation; optionally pulse start with junk operands at cycles p1/p2.
  // Returns at the negedge where done is seen; lat = -1 on timeout.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int p1, input int p2,
                        output logic [W-1:0] q, output logic [W-1:0] r,
                        output logic z, output int lat, output bit busy_ok);
    bit seen;
    seen = 0;
    busy_ok = 1;
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
    @(posedge clk);
    lat = 1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      bus.start = (lat == p1 || lat == p2);
      if (bus.start) begin
        bus.dividend = W'($urandom); bus.divisor = W'($urandom);
      end
      if (bus.busy !== 1'b1) busy_ok = 0;
      if (bus.done === 1'b1) begin
        q = bus.quotient; r = bus.remainder; z = bus.div_by_zero;
        seen = 1;
        break;
      end
      @(posedge clk);
      lat++;
    end
    if (!seen) begin
      lat = -1; q = 'x; r = 'x; z = 1'bx;
    end
  endtask

  task automatic check_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez,
                          input int elat, input int p1, input int p2);
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic z;
    int lat;
    bit bok;
    run_op(a, b, p1, p2, q, r, z, lat, bok);
    checks++;
    if (lat !== elat) begin
      errors++; $display("FAIL %s latency got %0d want %0d", name, lat, elat);
    end
    checks++;
    if (q !== eq || r !== er || z !== ez) begin
      errors++;
      $display("FAIL %s result got q=%h r=%h z=%b want q=%h r=%h z=%b", name, q, r, z, eq, er, ez);
    end
    checks++;
    if (!bok) begin
      errors++; $display("FAIL %s busy dropped during operation got 0 want 1", name);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.start = 1'b1; bus.dividend = 16'd5; bus.divisor = 16'd3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.quotient !== '0 ||
        bus.remainder !== '0 || bus.div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset state got busy=%b done=%b q=%h r=%h z=%b want all 0",
               bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero);
    end
    reset = 1'b0; bus.start = 1'b0;
  endtask

  task automatic test_basic();
    check_op("div_100_7", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 17, 0, 0);
    // Results must hold with done low until the next operation completes.
    repeat (4) @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.quotient !== 16'd14 || bus.remainder !== 16'd2) begin
      errors++;
      $display("FAIL hold got done=%b busy=%b q=%h r=%h want done=0 busy=0 q=000e r=0002",
               bus.done, bus.busy, bus.quotient, bus.remainder);
    end
  endtask

  task automatic test_boundaries();
    check_op("div_ffff_1", 16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0, 17, 0, 0);
    check_op("div_3_10", 16'd3, 16'd10, 16'd0, 16'd3, 1'b0, 17, 0, 0);
    check_op("div_5_0", 16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1, 1, 0, 0);
  endtask

  task automatic test_ignore_start();
    // Pulses at cycle 4 (RUN) and 17 (DONE) are ignored; the following
    // call starts in the first cycle after done and must be accepted.
    check_op("ignore_start", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 17, 4, 17);
    check_op("back_to_back", 16'd9, 16'd2, 16'd4, 16'd1, 1'b0, 17, 0, 0);
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL idle_after_op busy got %b want 0", bus.busy);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 16'd100; bus.divisor = 16'd7;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.quotient !== '0 ||
        bus.remainder !== '0 || bus.div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got busy=%b done=%b q=%h r=%h z=%b want all 0",
               bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero);
    end
    check_op("after_reset_9_3", 16'd9, 16'd3, 16'd3, 16'd0, 1'b0, 17, 0, 0);
  endtask

  task automatic test_random();
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic ez;
    int elat;
    for (int i = 0; i < 40; i++) begin
      a = W'($urandom);
      case ($urandom_range(0, 3))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 15));
        2:       b = W'($urandom_range(1, 300));
        default: b = W'($urandom);
      endcase
      if (i == 0) begin a = 16'h8000; b = 16'hFFFF; end
      model(a, b, eq, er, ez, elat);
      check_op("random", a, b, eq, er, ez, elat, 0, 0);
    end
  endtask

`ifdef DIV_SIGNED_EN
  task automatic test_signed();
    check_op("signed_m7_2", 16'hFFF9, 16'd2, 16'hFFFD, 16'hFFFF, 1'b0, 17, 0, 0);
    check_op("signed_min_m1", 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 17, 0, 0);
    check_op("signed_m5_0", 16'hFFFB, 16'd0, 16'hFFFF, 16'hFFFB, 1'b1, 1, 0, 0);
  endtask
`endif

  initial begin
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    test_reset();
    test_basic();
    test_boundaries();
    test_ignore_start();
    test_reset_mid();
`ifdef DIV_SIGNED_EN
    test_signed();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
